// File: rtl/reg_file_param.sv
// Parameterised register file with masked write modes, registered reads and access-error pulses.
// Registers 0..3 are also exposed as continuous outputs.
module reg_file_param #(
  parameter int unsigned             WIDTH    = 8,
  parameter int unsigned             DEPTH    = 16,
  parameter int unsigned             ADDR_W   = 4,
  parameter logic [WIDTH-1:0]        REG2_RST = WIDTH'(8'b1000_0001),
  parameter logic [WIDTH-1:0]        REG3_RST = WIDTH'(8'b0010_0000)
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              WrEn,
  input  logic              RdEn,
  input  logic [1:0]        WrMode,
  input  logic [ADDR_W-1:0] Address,
  input  logic [WIDTH-1:0]  WrData,
  output logic [WIDTH-1:0]  RdData,
  output logic              RdData_Valid,
  output logic              AccErr,
  output logic [WIDTH-1:0]  REG0,
  output logic [WIDTH-1:0]  REG1,
  output logic [WIDTH-1:0]  REG2,
  output logic [WIDTH-1:0]  REG3
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] new_val;
  logic             in_range;

  // Extra bit so DEPTH == 2**ADDR_W is representable.
  assign in_range = ({1'b0, Address} < (ADDR_W + 1)'(DEPTH));

  always_comb begin
    cur_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Address == ADDR_W'(i)) cur_val = regs[i];
    end
  end

  always_comb begin
    new_val = WrData;
    unique case (WrMode)
      2'b00: new_val = WrData;
      2'b01: new_val = cur_val | WrData;
      2'b10: new_val = cur_val & ~WrData;
      2'b11: new_val = cur_val ^ WrData;
      default: new_val = WrData;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == 2) ? REG2_RST : (i == 3) ? REG3_RST : '0;
      end
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      AccErr       <= 1'b0;
    end else begin
      RdData_Valid <= 1'b0;
      AccErr       <= 1'b0;
      if (WrEn && RdEn) begin
        AccErr <= 1'b1;
      end else if (WrEn) begin
        if (in_range) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (Address == ADDR_W'(i)) regs[i] <= new_val;
          end
        end else begin
          AccErr <= 1'b1;
        end
      end else if (RdEn) begin
        RdData_Valid <= 1'b1;
        if (in_range) begin
          RdData <= cur_val;
        end else begin
          RdData <= '0;
          AccErr <= 1'b1;
        end
      end
    end
  end

  assign REG0 = regs[0];
  assign REG1 = regs[1];
  assign REG2 = regs[2];
  assign REG3 = regs[3];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default, DEPTH=12 and WIDTH=16/DEPTH=8 instances share one clock.
module tb_reg_file_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Default instance
  logic       a_we = 0, a_re = 0;
  logic [1:0] a_mode = 0;
  logic [3:0] a_addr = 0;
  logic [7:0] a_wd = 0;
  logic [7:0] a_rd, a_r0, a_r1, a_r2, a_r3;
  logic       a_v, a_err;

  reg_file_param dut_a (
    .clk(clk), .RST(rst_n), .WrEn(a_we), .RdEn(a_re), .WrMode(a_mode), .Address(a_addr),
    .WrData(a_wd), .RdData(a_rd), .RdData_Valid(a_v), .AccErr(a_err),
    .REG0(a_r0), .REG1(a_r1), .REG2(a_r2), .REG3(a_r3)
  );

  // DEPTH=12 instance
  logic       b_we = 0, b_re = 0;
  logic [1:0] b_mode = 0;
  logic [3:0] b_addr = 0;
  logic [7:0] b_wd = 0;
  logic [7:0] b_rd, b_r0, b_r1, b_r2, b_r3;
  logic       b_v, b_err;

  reg_file_param #(.DEPTH(12)) dut_b (
    .clk(clk), .RST(rst_n), .WrEn(b_we), .RdEn(b_re), .WrMode(b_mode), .Address(b_addr),
    .WrData(b_wd), .RdData(b_rd), .RdData_Valid(b_v), .AccErr(b_err),
    .REG0(b_r0), .REG1(b_r1), .REG2(b_r2), .REG3(b_r3)
  );

  // WIDTH=16, DEPTH=8 instance
  logic        c_we = 0, c_re = 0;
  logic [1:0]  c_mode = 0;
  logic [3:0]  c_addr = 0;
  logic [15:0] c_wd = 0;
  logic [15:0] c_rd, c_r0, c_r1, c_r2, c_r3;
  logic        c_v, c_err;

  reg_file_param #(.WIDTH(16), .DEPTH(8)) dut_c (
    .clk(clk), .RST(rst_n), .WrEn(c_we), .RdEn(c_re), .WrMode(c_mode), .Address(c_addr),
    .WrData(c_wd), .RdData(c_rd), .RdData_Valid(c_v), .AccErr(c_err),
    .REG0(c_r0), .REG1(c_r1), .REG2(c_r2), .REG3(c_r3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input logic we, input logic re, input logic [1:0] m,
                      input logic [3:0] ad, input logic [7:0] d);
    a_we = we; a_re = re; a_mode = m; a_addr = ad; a_wd = d;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_reg2_c", 32'(c_r2), 'h0081);
    chk("rst_reg3_c", 32'(c_r3), 'h0020);

    // Dirty state so the reset check is meaningful
    a_op(1, 0, 2'b00, 0, 8'h55); tick();
    a_op(0, 1, 2'b00, 2, 8'h00); tick();
    a_op(0, 0, 2'b00, 0, 8'h00);
    chk("pre_rst_reg0", 32'(a_r0), 'h55);
    chk("pre_rst_rd", 32'(a_rd), 'h81);
    chk("pre_rst_valid", 32'(a_v), 1);

    // Mid-cycle asynchronous reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_reg0", 32'(a_r0), 'h00);
    chk("rst_reg1", 32'(a_r1), 'h00);
    chk("rst_reg2", 32'(a_r2), 'h81);
    chk("rst_reg3", 32'(a_r3), 'h20);
    chk("rst_rd", 32'(a_rd), 'h00);
    chk("rst_valid", 32'(a_v), 0);
    chk("rst_err", 32'(a_err), 0);
    #2 rst_n = 1'b1;

    // Write then read
    a_op(1, 0, 2'b00, 5, 8'h05); tick();
    a_op(0, 1, 2'b11, 5, 8'hFF); tick();
    a_op(0, 0, 2'b00, 0, 8'h00);
    chk("wr_rd_data", 32'(a_rd), 'h05);
    chk("wr_rd_valid", 32'(a_v), 1);
    chk("wr_rd_err", 32'(a_err), 0);
    tick();
    chk("valid_drop", 32'(a_v), 0);
    chk("rd_hold", 32'(a_rd), 'h05);

    // Bit operations on register 2
    a_op(1, 0, 2'b01, 2, 8'h0C); tick();
    chk("set_bits", 32'(a_r2), 'h8D);
    a_op(1, 0, 2'b10, 2, 8'h80); tick();
    chk("clr_bits", 32'(a_r2), 'h0D);
    a_op(1, 0, 2'b11, 2, 8'hFF); tick();
    chk("tgl_bits", 32'(a_r2), 'hF2);

    // Illegal simultaneous write and read
    a_op(1, 0, 2'b00, 1, 8'h3C); tick();
    a_op(1, 1, 2'b00, 1, 8'hFF); tick();
    a_op(0, 0, 2'b00, 0, 8'h00);
    chk("both_reg1", 32'(a_r1), 'h3C);
    chk("both_err", 32'(a_err), 1);
    chk("both_valid", 32'(a_v), 0);
    chk("both_rd", 32'(a_rd), 'h05);
    tick();
    chk("err_drop", 32'(a_err), 0);

    // Streaming reads over registers 0..3
    a_op(1, 0, 2'b00, 0, 8'h11); tick();
    a_op(0, 1, 2'b00, 0, 8'h00); tick();
    chk("stream0_rd", 32'(a_rd), 'h11);
    chk("stream0_v", 32'(a_v), 1);
    a_addr = 1; tick();
    chk("stream1_rd", 32'(a_rd), 'h3C);
    chk("stream1_v", 32'(a_v), 1);
    a_addr = 2; tick();
    chk("stream2_rd", 32'(a_rd), 'hF2);
    chk("stream2_v", 32'(a_v), 1);
    a_addr = 3; tick();
    a_op(0, 0, 2'b00, 0, 8'h00);
    chk("stream3_rd", 32'(a_rd), 'h20);
    chk("stream3_v", 32'(a_v), 1);
    tick();
    chk("stream_end_v", 32'(a_v), 0);

    // DEPTH=12: last legal address, then out-of-range accesses
    b_we = 1; b_addr = 11; b_wd = 8'hA5; tick();
    b_we = 0; b_re = 1; tick();
    chk("d12_rd11", 32'(b_rd), 'hA5);
    chk("d12_rd11_err", 32'(b_err), 0);
    b_re = 0; b_we = 1; b_addr = 13; b_wd = 8'h77; tick();
    chk("d12_wr13_err", 32'(b_err), 1);
    chk("d12_wr13_v", 32'(b_v), 0);
    b_we = 0; b_re = 1; tick();
    b_re = 0;
    chk("d12_rd13_rd", 32'(b_rd), 'h00);
    chk("d12_rd13_v", 32'(b_v), 1);
    chk("d12_rd13_err", 32'(b_err), 1);

    // WIDTH=16, DEPTH=8
    c_we = 1; c_addr = 7; c_wd = 16'hBEEF; tick();
    c_we = 0; c_re = 1; tick();
    c_re = 0;
    chk("w16_rd7", 32'(c_rd), 'hBEEF);
    chk("w16_rd7_v", 32'(c_v), 1);
    c_we = 1; c_addr = 8; c_wd = 16'h1234; tick();
    c_we = 0;
    chk("w16_wr8_err", 32'(c_err), 1);
    chk("w16_reg0", 32'(c_r0), 'h0000);
    chk("w16_reg1", 32'(c_r1), 'h0000);
    chk("w16_reg2", 32'(c_r2), 'h0081);
    chk("w16_reg3", 32'(c_r3), 'h0020);
    c_re = 1; c_addr = 7; tick();
    c_re = 0;
    chk("w16_rd7_again", 32'(c_rd), 'hBEEF);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
